// File: rtl/t07_regfile_pkg.sv
// Shared defaults and address-width helper for the t07 register file with load scoreboard.
package t07_regfile_pkg;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_NUM_RD   = 2;

   function automatic int addr_bits(input int num_regs);
      return $clog2(num_regs);
   endfunction
endpackage

// File: rtl/t07_reg_scoreboard.sv
// Per-register pending-load tracking and the reservation-conflict pulse.
module t07_reg_scoreboard
   import t07_regfile_pkg::*;
#(
   parameter  int NUM_REGS = DEF_NUM_REGS,
   localparam int ADDR_W   = addr_bits(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                rsv_en,
   input  logic [ADDR_W-1:0]   rsv_addr,
   input  logic                ld_en,
   input  logic [ADDR_W-1:0]   ld_addr,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                rsv_err
);
   logic [NUM_REGS-1:0] r_busy;
   logic                r_err;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic                w_rsv_go;
   logic                w_err_nxt;

   // A same-cycle reservation overrides the load's clear: the new load owns the register.
   always_comb begin
      w_rsv_go   = enable & rsv_en & (rsv_addr != '0);
      w_busy_nxt = r_busy;
      if (ld_en)
         w_busy_nxt[ld_addr] = 1'b0;
      if (w_rsv_go)
         w_busy_nxt[rsv_addr] = 1'b1;
      w_busy_nxt[0] = 1'b0;
      w_err_nxt = w_rsv_go & r_busy[rsv_addr] & ~(ld_en & (ld_addr == rsv_addr));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
         r_err  <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_err  <= w_err_nxt;
      end
   end

   assign busy_vec = r_busy;
   assign rsv_err  = r_err;
endmodule

// File: rtl/t07_regfile_sb.sv
// Register file with ALU writeback, load return, same-cycle bypass and load scoreboard.
module t07_regfile_sb
   import t07_regfile_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int NUM_REGS = DEF_NUM_REGS,
   parameter  int NUM_RD   = DEF_NUM_RD,
   localparam int ADDR_W   = addr_bits(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_ready,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic                     ld_en,
   input  logic [ADDR_W-1:0]        ld_addr,
   input  logic [DATA_W-1:0]        ld_data,
   output logic [NUM_REGS-1:0]      busy_vec,
   output logic                     rsv_err
);
   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] w_busy;
   logic                w_wr_go;
   logic                w_ld_go;

   assign w_wr_go = enable & wr_en & (wr_addr != '0);
   assign w_ld_go = ld_en & (ld_addr != '0);

   // The load write comes last so it wins an address collision with the ALU writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < NUM_REGS; j++)
            r_regs[j] <= '0;
      end else begin
         if (w_wr_go)
            r_regs[wr_addr] <= wr_data;
         if (w_ld_go)
            r_regs[ld_addr] <= ld_data;
      end
   end

   t07_reg_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .busy_vec (w_busy),
      .rsv_err  (rsv_err)
   );

   assign busy_vec = w_busy;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;

      assign w_ra = rd_addr[i*ADDR_W +: ADDR_W];

      always_comb begin
         w_rd = r_regs[w_ra];
         if (enable && wr_en && (wr_addr == w_ra))
            w_rd = wr_data;
         if (ld_en && (ld_addr == w_ra))
            w_rd = ld_data;
         if (rst || (w_ra == '0))
            w_rd = '0;
      end

      assign rd_data[i*DATA_W +: DATA_W] = w_rd;
      assign rd_ready[i] = (w_ra == '0) | (ld_en & (ld_addr == w_ra)) | ~w_busy[w_ra];
   end
endmodule
